// File: rtl/sap1_pkg.sv
// ---------------------------------------------------------------------------
// sap1_pkg
// Architectural constants shared by the SAP-1 controller-sequencer:
//   opcode_t  - the instruction-register opcodes the control matrix decodes
//   con_t     - the 12-bit control word, MSB first:
//               {CP,EP,LM_BAR,CE_BAR,LI_BAR,EI_BAR,LA_BAR,EA,SU,EU,LB_BAR,LO_BAR}
//   tstate_t  - one-hot ring-counter state, T1..T6
//   CON_*     - control-word constants per timing state
// ---------------------------------------------------------------------------
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_bar;
        logic ce_bar;
        logic li_bar;
        logic ei_bar;
        logic la_bar;
        logic ea;
        logic su;
        logic eu;
        logic lb_bar;
        logic lo_bar;
    } con_t;

    typedef logic [5:0] tstate_t;

    localparam tstate_t T1 = 6'b000001;
    localparam tstate_t T2 = 6'b000010;
    localparam tstate_t T3 = 6'b000100;
    localparam tstate_t T4 = 6'b001000;
    localparam tstate_t T5 = 6'b010000;
    localparam tstate_t T6 = 6'b100000;

    // Idle word: every active-low load/enable deasserted, nothing on the bus.
    localparam con_t CON_IDLE     = 12'h3E3;
    // Fetch cycle, common to every opcode.
    localparam con_t CON_FETCH_T1 = 12'h5E3;   // EP, LM_BAR: PC -> MAR
    localparam con_t CON_FETCH_T2 = 12'hBE3;   // CP: PC increments
    localparam con_t CON_FETCH_T3 = 12'h263;   // CE_BAR, LI_BAR: RAM -> IR
    // Execute cycle.
    localparam con_t CON_MEM_T4   = 12'h1A3;   // EI_BAR, LM_BAR: IR operand -> MAR
    localparam con_t CON_LDA_T5   = 12'h2C3;   // CE_BAR, LA_BAR: RAM -> A
    localparam con_t CON_ALU_T5   = 12'h2E1;   // CE_BAR, LB_BAR: RAM -> B
    localparam con_t CON_ADD_T6   = 12'h3C7;   // EU, LA_BAR: A+B -> A
    localparam con_t CON_SUB_T6   = 12'h3CF;   // SU, EU, LA_BAR: A-B -> A
    localparam con_t CON_OUT_T4   = 12'h3F2;   // EA, LO_BAR: A -> output register

    // Ring successor; any non-one-hot encoding falls back to T1.
    function automatic tstate_t next_tstate(input tstate_t t);
        tstate_t n;
        case (t)
            T1:      n = T2;
            T2:      n = T3;
            T3:      n = T4;
            T4:      n = T5;
            T5:      n = T6;
            T6:      n = T1;
            default: n = T1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ring_counter_bh.sv
// ---------------------------------------------------------------------------
// ring_counter_bh
// Six-state one-hot ring counter for the SAP-1 sequencer. Advances on the
// falling clock edge so the control word settles half a cycle before the
// datapath loads on the rising edge.
// Ports:
//   CLK      in   clock (state advances on negedge)
//   CLR_BAR  in   asynchronous active-low clear, forces T1
//   HOLD     in   freeze the current state (used by the halt logic)
//   T[5:0]   out  one-hot state, T[0]=T1 .. T[5]=T6
// ---------------------------------------------------------------------------
module ring_counter_bh
    import sap1_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR_BAR,
    input  logic       HOLD,
    output logic [5:0] T
);

    tstate_t r_t;

    // One-hot ring state; HOLD only freezes a legal state so a corrupted
    // encoding always recovers at the next edge.
    always_ff @(negedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            r_t <= T1;
        end else if (HOLD && $onehot(r_t)) begin
            r_t <= r_t;
        end else begin
            r_t <= next_tstate(r_t);
        end
    end

    assign T = r_t;

endmodule

// File: rtl/controller_sequencer_bh.sv
// ---------------------------------------------------------------------------
// controller_sequencer_bh
// SAP-1 controller-sequencer: one-hot ring counter plus the control matrix
// that produces the 12-bit control word for the whole datapath.
// Ports:
//   CLK       in   system clock; T advances on negedge, datapath loads on posedge
//   CLR_BAR   in   asynchronous active-low clear
//   OPCODE    in   IR[7:4], valid from T4 onward
//   T[5:0]    out  one-hot ring state
//   CON[11:0] out  {CP,EP,LM_BAR,CE_BAR,LI_BAR,EI_BAR,LA_BAR,EA,SU,EU,LB_BAR,LO_BAR}
//   HLT_BAR   out  low = clock must stop
// Build option: define SAP1_HLT_EN to enable the HLT (1111) instruction.
// Without it HLT_BAR is tied high and 1111 executes as a NOP.
// ---------------------------------------------------------------------------
module controller_sequencer_bh
    import sap1_pkg::*;
(
    input  logic        CLK,
    input  logic        CLR_BAR,
    input  logic [3:0]  OPCODE,
    output logic [5:0]  T,
    output logic [11:0] CON,
    output logic        HLT_BAR
);

    logic w_hold;
    logic w_halted;
    con_t w_con;

    ring_counter_bh u_ring (
        .CLK     (CLK),
        .CLR_BAR (CLR_BAR),
        .HOLD    (w_hold),
        .T       (T)
    );

`ifdef SAP1_HLT_EN
    logic w_hlt_req;
    logic r_halted;

    // HLT decoded in T4 drops HLT_BAR immediately; the same term holds the
    // ring at the coming negedge so T never leaves T4.
    assign w_hlt_req = CLR_BAR & (T == T4) & (OPCODE == OP_HLT);

    // Sticky halted flag, cleared only by CLR_BAR.
    always_ff @(negedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            r_halted <= 1'b0;
        end else if (w_hlt_req) begin
            r_halted <= 1'b1;
        end else begin
            r_halted <= r_halted;
        end
    end

    assign w_halted = r_halted;
    assign w_hold   = r_halted | w_hlt_req;
    assign HLT_BAR  = ~w_hold;
`else
    assign w_halted = 1'b0;
    assign w_hold   = 1'b0;
    assign HLT_BAR  = 1'b1;
`endif

    // Control matrix. Clear is folded in combinationally so the word goes
    // idle the instant CLR_BAR falls, not at the next clock edge.
    always_comb begin
        w_con = CON_IDLE;
        if (!CLR_BAR) begin
            w_con = CON_IDLE;
        end else if (w_halted) begin
            w_con = CON_IDLE;
        end else begin
            case (T)
                T1: w_con = CON_FETCH_T1;
                T2: w_con = CON_FETCH_T2;
                T3: w_con = CON_FETCH_T3;
                T4: begin
                    case (OPCODE)
                        OP_LDA:  w_con = CON_MEM_T4;
                        OP_ADD:  w_con = CON_MEM_T4;
                        OP_SUB:  w_con = CON_MEM_T4;
                        OP_OUT:  w_con = CON_OUT_T4;
                        default: w_con = CON_IDLE;
                    endcase
                end
                T5: begin
                    case (OPCODE)
                        OP_LDA:  w_con = CON_LDA_T5;
                        OP_ADD:  w_con = CON_ALU_T5;
                        OP_SUB:  w_con = CON_ALU_T5;
                        default: w_con = CON_IDLE;
                    endcase
                end
                T6: begin
                    case (OPCODE)
                        OP_ADD:  w_con = CON_ADD_T6;
                        OP_SUB:  w_con = CON_SUB_T6;
                        default: w_con = CON_IDLE;
                    endcase
                end
                default: w_con = CON_IDLE;
            endcase
        end
    end

    assign CON = w_con;

endmodule

// File: tb/tb_controller_sequencer_bh.sv
// ---------------------------------------------------------------------------
// tb_controller_sequencer_bh
// Self-checking bench for the SAP-1 controller-sequencer. A reference model
// tracks the step number within the instruction (0..5) and the halted state,
// and looks the control word up in per-opcode tables.
// ---------------------------------------------------------------------------
module tb_controller_sequencer_bh;

    logic        CLK;
    logic        CLR_BAR;
    logic [3:0]  OPCODE;
    logic [5:0]  T;
    logic [11:0] CON;
    logic        HLT_BAR;

    int errors = 0;
    int checks = 0;

`ifdef SAP1_HLT_EN
    localparam bit HLT_EN = 1'b1;
`else
    localparam bit HLT_EN = 1'b0;
`endif

    // Reference model state
    int m_step   = 0;   // 0 = T1 .. 5 = T6
    bit m_halted = 1'b0;

    controller_sequencer_bh dut (
        .CLK     (CLK),
        .CLR_BAR (CLR_BAR),
        .OPCODE  (OPCODE),
        .T       (T),
        .CON     (CON),
        .HLT_BAR (HLT_BAR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Control word from the instruction tables.
    function automatic logic [11:0] ref_con(input int step, input logic [3:0] op,
                                            input bit halted, input logic clr);
        logic [11:0] fetch [0:2];
        logic [11:0] ex    [0:2];
        fetch[0] = 12'h5E3; fetch[1] = 12'hBE3; fetch[2] = 12'h263;
        case (op)
            4'b0000: begin ex[0] = 12'h1A3; ex[1] = 12'h2C3; ex[2] = 12'h3E3; end
            4'b0001: begin ex[0] = 12'h1A3; ex[1] = 12'h2E1; ex[2] = 12'h3C7; end
            4'b0010: begin ex[0] = 12'h1A3; ex[1] = 12'h2E1; ex[2] = 12'h3CF; end
            4'b1110: begin ex[0] = 12'h3F2; ex[1] = 12'h3E3; ex[2] = 12'h3E3; end
            default: begin ex[0] = 12'h3E3; ex[1] = 12'h3E3; ex[2] = 12'h3E3; end
        endcase
        if (!clr || halted) return 12'h3E3;
        if (step < 3) return fetch[step];
        return ex[step - 3];
    endfunction

    // Expected outputs for the model's current state and the present inputs.
    task automatic model_expect(output logic [5:0] et, output logic [11:0] ec, output logic eh);
        et = 6'b000001 << m_step;
        ec = ref_con(m_step, OPCODE, m_halted, CLR_BAR);
        eh = !(HLT_EN && CLR_BAR && (m_halted || (m_step == 3 && OPCODE == 4'b1111)));
    endtask

    // One falling edge: advance the model with the inputs seen at the edge,
    // then settle 2 time units before anything is sampled.
    task automatic tick();
        @(negedge CLK);
        if (!CLR_BAR) begin
            m_step = 0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_step = m_step;
        end else if (HLT_EN && m_step == 3 && OPCODE == 4'b1111) begin
            m_halted = 1'b1;
        end else begin
            m_step = (m_step + 1) % 6;
        end
        #2;
    endtask

    task automatic assert_clear();
        CLR_BAR = 1'b0;
        m_step = 0; m_halted = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] et; logic [11:0] ec; logic eh;
        OPCODE = 4'b0000;
        assert_clear();
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            model_expect(et, ec, eh);
            checks++;
            if (T !== et || CON !== ec || HLT_BAR !== eh) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got T=%b CON=%h HLT_BAR=%b, expected T=%b CON=%h HLT_BAR=%b",
                         i, T, CON, HLT_BAR, et, ec, eh);
            end
        end
        @(posedge CLK); #1;
        CLR_BAR = 1'b1;
        #1;
        model_expect(et, ec, eh);
        checks++;
        if (T !== 6'b000001 || CON !== 12'h5E3 || T !== et || CON !== ec) begin
            errors++;
            $display("FAIL reset_release: got T=%b CON=%h, expected T=000001 CON=5e3", T, CON);
        end
        tick();
        checks++;
        if (T !== 6'b000010 || CON !== 12'hBE3) begin
            errors++;
            $display("FAIL reset_first_negedge: got T=%b CON=%h, expected T=000010 CON=be3", T, CON);
        end
        while (m_step != 0) tick();
    endtask

    task automatic test_lda();
        logic [5:0] et; logic [11:0] ec; logic eh;
        OPCODE = 4'b0000;
        #1;
        for (int s = 0; s < 6; s++) begin
            model_expect(et, ec, eh);
            checks++;
            if (T !== et || CON !== ec || HLT_BAR !== eh) begin
                errors++;
                $display("FAIL lda_T%0d: got T=%b CON=%h HLT_BAR=%b, expected T=%b CON=%h HLT_BAR=%b",
                         s + 1, T, CON, HLT_BAR, et, ec, eh);
            end
            tick();
        end
        checks++;
        if (T !== 6'b000001) begin
            errors++;
            $display("FAIL lda_wrap: got T=%b, expected T=000001", T);
        end
    endtask

    task automatic test_exec_ops();
        logic [5:0] et; logic [11:0] ec; logic eh;
        logic [3:0] ops [0:3];
        ops[0] = 4'b0001; ops[1] = 4'b0010; ops[2] = 4'b1110; ops[3] = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            OPCODE = ops[k];
            #1;
            for (int s = 0; s < 6; s++) begin
                model_expect(et, ec, eh);
                checks++;
                if (T !== et || CON !== ec || HLT_BAR !== eh) begin
                    errors++;
                    $display("FAIL op%b_T%0d: got T=%b CON=%h HLT_BAR=%b, expected T=%b CON=%h HLT_BAR=%b",
                             ops[k], s + 1, T, CON, HLT_BAR, et, ec, eh);
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] et; logic [11:0] ec; logic eh;
        for (int n = 0; n < 120; n++) begin
            OPCODE = 4'($urandom_range(0, 14));
            #1;
            model_expect(et, ec, eh);
            checks++;
            if (T !== et || CON !== ec || HLT_BAR !== eh) begin
                errors++;
                $display("FAIL random[%0d] op=%b: got T=%b CON=%h HLT_BAR=%b, expected T=%b CON=%h HLT_BAR=%b",
                         n, OPCODE, T, CON, HLT_BAR, et, ec, eh);
            end
            tick();
        end
        while (m_step != 0) tick();
    endtask

    task automatic test_halt();
        logic [5:0] et; logic [11:0] ec; logic eh;
        OPCODE = 4'b1111;
        #1;
`ifdef SAP1_HLT_EN
        for (int s = 0; s < 3; s++) tick();
        checks++;
        if (T !== 6'b001000 || HLT_BAR !== 1'b0 || CON !== 12'h3E3) begin
            errors++;
            $display("FAIL halt_T4: got T=%b CON=%h HLT_BAR=%b, expected T=001000 CON=3e3 HLT_BAR=0",
                     T, CON, HLT_BAR);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            OPCODE = 4'($urandom_range(0, 15));
            #1;
            model_expect(et, ec, eh);
            checks++;
            if (T !== 6'b001000 || CON !== 12'h3E3 || HLT_BAR !== 1'b0 || T !== et || CON !== ec) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got T=%b CON=%h HLT_BAR=%b, expected T=001000 CON=3e3 HLT_BAR=0",
                         c, T, CON, HLT_BAR);
            end
        end
        assert_clear();
        #1;
        checks++;
        if (T !== 6'b000001 || HLT_BAR !== 1'b1 || CON !== 12'h3E3) begin
            errors++;
            $display("FAIL halt_clear: got T=%b CON=%h HLT_BAR=%b, expected T=000001 CON=3e3 HLT_BAR=1",
                     T, CON, HLT_BAR);
        end
        tick();
        @(posedge CLK); #1;
        CLR_BAR = 1'b1;
        OPCODE = 4'b0000;
        #1;
`else
        for (int s = 0; s < 6; s++) begin
            model_expect(et, ec, eh);
            checks++;
            if (T !== et || CON !== ec || HLT_BAR !== 1'b1) begin
                errors++;
                $display("FAIL hlt_nop_T%0d: got T=%b CON=%h HLT_BAR=%b, expected T=%b CON=%h HLT_BAR=1",
                         s + 1, T, CON, HLT_BAR, et, ec);
            end
            tick();
        end
`endif
        model_expect(et, ec, eh);
        checks++;
        if (T !== 6'b000001 || HLT_BAR !== 1'b1 || T !== et || CON !== ec) begin
            errors++;
            $display("FAIL halt_after: got T=%b CON=%h HLT_BAR=%b, expected T=000001 CON=%h HLT_BAR=1",
                     T, CON, HLT_BAR, ec);
        end
    endtask

    task automatic test_async_clear();
        logic [5:0] et; logic [11:0] ec; logic eh;
        OPCODE = 4'b0000;
        #1;
        for (int s = 0; s < 4; s++) tick();
        checks++;
        if (T !== 6'b010000 || CON !== 12'h2C3) begin
            errors++;
            $display("FAIL async_pre_T5: got T=%b CON=%h, expected T=010000 CON=2c3", T, CON);
        end
        #1;
        assert_clear();
        #1;
        checks++;
        if (T !== 6'b000001 || CON !== 12'h3E3 || HLT_BAR !== 1'b1) begin
            errors++;
            $display("FAIL async_clear: got T=%b CON=%h HLT_BAR=%b, expected T=000001 CON=3e3 HLT_BAR=1",
                     T, CON, HLT_BAR);
        end
        tick();
        @(posedge CLK); #1;
        CLR_BAR = 1'b1;
        #1;
        model_expect(et, ec, eh);
        checks++;
        if (T !== et || CON !== ec || CON !== 12'h5E3) begin
            errors++;
            $display("FAIL async_release: got T=%b CON=%h, expected T=%b CON=%h", T, CON, et, ec);
        end
        tick();
        model_expect(et, ec, eh);
        checks++;
        if (T !== et || CON !== ec) begin
            errors++;
            $display("FAIL async_resume: got T=%b CON=%h, expected T=%b CON=%h", T, CON, et, ec);
        end
    endtask

    initial begin
        CLR_BAR = 1'b0;
        OPCODE  = 4'b0000;
        test_reset();
        test_lda();
        test_exec_ops();
        test_random();
        test_halt();
        test_async_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
